bpc_plane_decoder: RTL



---
 rtl/ebpc_pkg.sv | 23 ++
 rtl/bpc_symbol_expander.sv | 82 ++++++++
 rtl/bpc_plane_decoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ebpc_pkg.sv
// Shared symbol kinds and prefix codes for the bit-plane (BPC) symbol decoder.
// Prefixes are matched MSB-first against the top of the unpacker window.
package ebpc_pkg;

  typedef enum logic [2:0] {
    ZERO1,
    ZRUN,
    ONES,
    DBP0,
    TWO1,
    ONE1,
    RAW
  } symb_kind_t;

  localparam logic       PFX_RAW   = 1'b1;
  localparam logic [1:0] PFX_ZERO1 = 2'b01;
  localparam logic [2:0] PFX_ZRUN  = 3'b001;
  localparam logic [4:0] PFX_ONES  = 5'b00000;
  localparam logic [4:0] PFX_DBP0  = 5'b00001;
  localparam logic [4:0] PFX_TWO1  = 5'b00010;
  localparam logic [4:0] PFX_ONE1  = 5'b00011;

endpackage

// File: rtl/bpc_symbol_expander.sv
// Combinational decode of the BPC symbol at the top of the window into kind,
// length, run length and the DBX plane; zero latency, no flow control of its own.
module bpc_symbol_expander
  import ebpc_pkg::*;
#(
  parameter  int WORD_W     = 8,
  parameter  int BLOCK_SIZE = 8,
  localparam int PW         = BLOCK_SIZE - 1,
  localparam int LW         = $clog2(WORD_W + 1)
) (
  input  logic [WORD_W-1:0] data_i,
  output symb_kind_t        kind_o,
  output logic [LW-1:0]     len_o,
  output logic [LW-1:0]     run_len_o,
  output logic [PW-1:0]     dbx_o,
  output logic              is_dbp_o,
  output logic              pos_err_o
);

  localparam int LOG_W = $clog2(WORD_W);
  localparam int LOG_P = $clog2(PW);

  logic [4:0]       pfx;
  logic [LOG_W-1:0] run_r;
  logic [LOG_P-1:0] pos;
  logic [PW-1:0]    one_hot;

  assign pfx     = data_i[WORD_W-1 -: 5];
  assign run_r   = data_i[WORD_W-4 -: LOG_W];
  assign pos     = data_i[WORD_W-6 -: LOG_P];
  assign one_hot = PW'(1) << pos;

  always_comb begin
    kind_o    = RAW;
    len_o     = LW'(BLOCK_SIZE);
    run_len_o = LW'(1);
    dbx_o     = data_i[WORD_W-2 -: PW];
    is_dbp_o  = 1'b0;
    pos_err_o = 1'b0;
    if (pfx[4] == PFX_RAW) begin
      kind_o = RAW;
    end else if (pfx[4:3] == PFX_ZERO1) begin
      kind_o = ZERO1;
      len_o  = LW'(2);
      dbx_o  = '0;
    end else if (pfx[4:2] == PFX_ZRUN) begin
      kind_o    = ZRUN;
      len_o     = LW'(3 + LOG_W);
      run_len_o = LW'(run_r) + LW'(2);
      dbx_o     = '0;
    end else begin
      case (pfx)
        PFX_ONES: begin
          kind_o = ONES;
          len_o  = LW'(5);
          dbx_o  = '1;
        end
        PFX_DBP0: begin
          kind_o   = DBP0;
          len_o    = LW'(5);
          dbx_o    = '0;
          is_dbp_o = 1'b1;
        end
        // p = PW-1 has no partner bit: the upper one falls off the plane.
        PFX_TWO1: begin
          kind_o    = TWO1;
          len_o     = LW'(5 + LOG_P);
          dbx_o     = one_hot | (one_hot << 1);
          pos_err_o = {1'b0, pos} >= (LOG_P + 1)'(PW - 1);
        end
        PFX_ONE1: begin
          kind_o    = ONE1;
          len_o     = LW'(5 + LOG_P);
          dbx_o     = one_hot;
          pos_err_o = {1'b0, pos} >= (LOG_P + 1)'(PW);
        end
        default: kind_o = RAW;
      endcase
    end
  end

endmodule

// File: rtl/bpc_plane_decoder.sv
// Per block: base word, then WORD_W+1 delta bit-planes decoded from BPC symbols.
// Zero-latency window-to-output path; out_rdy_i low freezes all state.
module bpc_plane_decoder
  import ebpc_pkg::*;
#(
  parameter  int WORD_W     = 8,
  parameter  int BLOCK_SIZE = 8,
  localparam int LW         = $clog2(WORD_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [LW-1:0]     fill_i,
  input  logic              data_vld_i,
  output logic              data_rdy_o,
  output logic [LW-1:0]     len_o,
  output logic [WORD_W-1:0] out_data_o,
  output logic              out_base_o,
  output logic              out_last_o,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic              done_o,
  output logic              err_o
);

  localparam int PW = BLOCK_SIZE - 1;
  localparam logic [LW-1:0] LEN_W = LW'(WORD_W);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLANE = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  if (BLOCK_SIZE > WORD_W || BLOCK_SIZE < 3 || 5 + $clog2(BLOCK_SIZE - 1) > WORD_W ||
      (WORD_W & (WORD_W - 1)) != 0) begin : g_bad_params
    $error("bpc_plane_decoder: illegal WORD_W/BLOCK_SIZE combination");
  end

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] plane_cnt_q, plane_cnt_d;
  logic [LW-1:0] run_cnt_q, run_cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [PW-1:0] dbp_q, dbp_d;
  logic          err_q, err_d;

  symb_kind_t    sym_kind;
  logic [LW-1:0] sym_len, sym_run_len;
  logic [PW-1:0] sym_dbx;
  logic          sym_is_dbp, sym_pos_err;

  bpc_symbol_expander #(
    .WORD_W     (WORD_W),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_expander (
    .data_i    (data_i),
    .kind_o    (sym_kind),
    .len_o     (sym_len),
    .run_len_o (sym_run_len),
    .dbx_o     (sym_dbx),
    .is_dbp_o  (sym_is_dbp),
    .pos_err_o (sym_pos_err)
  );

  logic          hs, plane_last, run_clamped;
  logic [LW-1:0] planes_left, run_eff;
  logic [PW-1:0] plane_dbp;

  assign plane_last  = plane_cnt_q == LEN_W;
  assign planes_left = LEN_W - plane_cnt_q + LW'(1);
  assign run_clamped = (sym_kind == ZRUN) && (sym_run_len > planes_left);
  assign run_eff     = (sym_kind != ZRUN) ? LW'(1) : (run_clamped ? planes_left : sym_run_len);
  assign plane_dbp   = (state_q == S_RUN) ? dbp_q : (sym_is_dbp ? '0 : (sym_dbx ^ dbp_q));

  // The closing run handshake needs a live window so the consume is not lost.
  always_comb begin
    case (state_q)
      S_IDLE:  out_vld_o = data_vld_i && (fill_i >= LEN_W);
      S_PLANE: out_vld_o = data_vld_i && (fill_i >= sym_len);
      S_RUN:   out_vld_o = (run_cnt_q != LW'(1)) || data_vld_i;
      default: out_vld_o = 1'b0;
    endcase
  end

  assign hs         = out_vld_o & out_rdy_i;
  assign out_base_o = state_q == S_IDLE;
  assign out_last_o = (state_q != S_IDLE) && plane_last;
  assign out_data_o = out_base_o ? data_i : {plane_dbp, {(WORD_W - PW){1'b0}}};
  assign len_o      = (state_q == S_IDLE) ? LEN_W : ((state_q == S_RUN) ? len_q : sym_len);
  assign done_o     = hs && out_last_o;
  assign err_o      = err_q;

  always_comb begin
    state_d     = state_q;
    plane_cnt_d = plane_cnt_q;
    run_cnt_d   = run_cnt_q;
    len_d       = len_q;
    dbp_d       = dbp_q;
    err_d       = err_q;
    data_rdy_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          data_rdy_o = 1'b1;
          state_d    = S_PLANE;
        end
      end
      S_PLANE: begin
        if (hs) begin
          dbp_d       = plane_dbp;
          plane_cnt_d = plane_cnt_q + LW'(1);
          if (run_clamped || sym_pos_err) err_d = 1'b1;
          if (run_eff > LW'(1)) begin
            run_cnt_d = run_eff - LW'(1);
            len_d     = sym_len;
            state_d   = S_RUN;
          end else begin
            data_rdy_o = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (hs) begin
          plane_cnt_d = plane_cnt_q + LW'(1);
          run_cnt_d   = run_cnt_q - LW'(1);
          if (run_cnt_q == LW'(1)) begin
            data_rdy_o = 1'b1;
            state_d    = S_PLANE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (done_o) begin
      state_d     = S_IDLE;
      plane_cnt_d = '0;
      run_cnt_d   = '0;
      dbp_d       = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state_q     <= S_IDLE;
      plane_cnt_q <= '0;
      run_cnt_q   <= '0;
      len_q       <= LEN_W;
      dbp_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      plane_cnt_q <= plane_cnt_d;
      run_cnt_q   <= run_cnt_d;
      len_q       <= len_d;
      dbp_q       <= dbp_d;
      err_q       <= err_d;
    end
  end

endmodule
